// File: rtl/seq_shifter.sv
// seq_shifter: bit-serial LSL/LSR/ASR/(ROR) shift unit with valid/ready handshakes
// Optional rotate-right is enabled by defining SEQ_SHIFTER_ROR_EN.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   in_valid/in_ready   request handshake (in_ready high only in IDLE)
//   in_data, op, amt    operand, opcode (000 pass 001 LSL 010 LSR 011 ASR 100 ROR), shift amount
//   out_valid/out_ready result handshake (out_valid high only in DONE)
//   sout, cout          registered result and last bit shifted/rotated out
module seq_shifter #(
    parameter int WIDTH = 16,
    parameter int AMT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [2:0]       op,
    input  logic [AMT_W-1:0] amt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sout,
    output logic             cout
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;
    localparam logic [AMT_W-1:0] W_AMT = AMT_W'(WIDTH);

    logic [1:0]       state;
    logic [WIDTH-1:0] work, step;
    logic             wcout, step_c;
    logic [2:0]       op_q;
    logic [AMT_W-1:0] cnt, load_cnt, sat;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign sat       = (amt >= W_AMT) ? W_AMT : amt;

    always_comb begin
        load_cnt = '0;
        case (op)
            3'b001, 3'b010, 3'b011: load_cnt = sat;
`ifdef SEQ_SHIFTER_ROR_EN
            3'b100: load_cnt = amt % W_AMT;
`endif
            default: load_cnt = '0;
        endcase
    end

    // One-bit step of the latched operation; pass codes never step (count is 0).
    always_comb begin
        step   = work;
        step_c = wcout;
        case (op_q)
            3'b001: begin step = {work[WIDTH-2:0], 1'b0};        step_c = work[WIDTH-1]; end
            3'b010: begin step = {1'b0, work[WIDTH-1:1]};        step_c = work[0];       end
            3'b011: begin step = {work[WIDTH-1], work[WIDTH-1:1]}; step_c = work[0];     end
`ifdef SEQ_SHIFTER_ROR_EN
            3'b100: begin step = {work[0], work[WIDTH-1:1]};     step_c = work[0];       end
`endif
            default: begin step = work; step_c = wcout; end
        endcase
    end

    // sout/cout are separate from the working register so the previous
    // result stays visible until the next one is ready.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            work  <= '0;
            wcout <= 1'b0;
            op_q  <= '0;
            cnt   <= '0;
            sout  <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    work  <= in_data;
                    op_q  <= op;
                    wcout <= 1'b0;
                    cnt   <= load_cnt;
                    state <= SHIFT;
                end
                SHIFT: if (cnt == '0) begin
                    sout  <= work;
                    cout  <= wcout;
                    state <= DONE;
                end else begin
                    work  <= step;
                    wcout <= step_c;
                    cnt   <= cnt - AMT_W'(1);
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
